// File: rtl/rom_access_arbiter_if.sv
// Requester and ROM-side signal bundle for rom_access_arbiter.
// slave = arbiter view; master = requesters plus ROM model view.
interface rom_access_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  REQ0;
    logic [ADDR_WIDTH-1:0] ADDR0;
    logic [DATA_WIDTH-1:0] RDATA0;
    logic                  VALID0;

    logic                  REQ1;
    logic [ADDR_WIDTH-1:0] ADDR1;
    logic [DATA_WIDTH-1:0] RDATA1;
    logic                  VALID1;

    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [DATA_WIDTH-1:0] ROM_DATA;
    logic                  BUSY;

    modport slave (
        input  REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        output RDATA0, VALID0, RDATA1, VALID1, ROM_ADDR, BUSY
    );

    modport master (
        output REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        input  RDATA0, VALID0, RDATA1, VALID1, ROM_ADDR, BUSY
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one 1-cycle registered-read ROM between two read ports.
// Optional one-entry last-read hit buffer enabled by defining ROM_ARB_LASTHIT_EN.
module rom_access_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    rom_access_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0]            state;
    logic                  owner;
    logic                  prio;
    logic                  any_req;
    logic                  win;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  valid0;
    logic                  valid1;

    // prio names the port that wins a tie; it flips to the loser after every grant.
    always_comb begin
        any_req  = bus.REQ0 | bus.REQ1;
        win      = (bus.REQ0 & bus.REQ1) ? prio : bus.REQ1;
        win_addr = win ? bus.ADDR1 : bus.ADDR0;
    end

`ifdef ROM_ARB_LASTHIT_EN
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0] last_data;
    logic                  last_vld;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_addr <= '0;
            last_data <= '0;
            last_vld  <= 1'b0;
        end else if (state == ST_READ) begin
            last_addr <= rom_addr;
            last_data <= bus.ROM_DATA;
            last_vld  <= 1'b1;
        end
    end

    assign hit      = last_vld && (win_addr == last_addr);
    assign hit_data = last_data;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            prio     <= 1'b0;
            rom_addr <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        prio <= ~win;
                        // A hit answers from the buffer and leaves ROM_ADDR untouched.
                        if (hit) begin
                            if (win) begin
                                rdata1 <= hit_data;
                                valid1 <= 1'b1;
                            end else begin
                                rdata0 <= hit_data;
                                valid0 <= 1'b1;
                            end
                        end else begin
                            rom_addr <= win_addr;
                            owner    <= win;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    if (owner) begin
                        rdata1 <= bus.ROM_DATA;
                        valid1 <= 1'b1;
                    end else begin
                        rdata0 <= bus.ROM_DATA;
                        valid0 <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ROM_ADDR = rom_addr;
    assign bus.RDATA0   = rdata0;
    assign bus.RDATA1   = rdata1;
    assign bus.VALID0   = valid0;
    assign bus.VALID1   = valid1;
    assign bus.BUSY     = (state != ST_IDLE);
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scoreboard bench for rom_access_arbiter: directed requests push expected responses,
// a monitor pops and compares on every VALID pulse.
module tb_rom_access_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RESET_N;

    rom_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    // ROM image: word = address ^ 8'hB5, so ROM[0x10] = 0xA5
    logic [DW-1:0] rom [256];
    logic [DW-1:0] rom_q;
    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ia;
            ia = i[7:0];
            rom[i] = ia ^ 8'hB5;
        end
    end
    always @(posedge CLK) rom_q <= rom[bus.ROM_ADDR];
    assign bus.ROM_DATA = rom_q;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [7:0]  data;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rd0 = '0;
    logic [7:0] exp_rd1 = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input int due);
        exp_t e;
        e.port = p;
        e.data = d;
        e.due  = due;
        sbq.push_back(e);
    endtask

    // Monitor: compares every VALID pulse against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.VALID0 || bus.VALID1) begin
                chk("valid_exclusive", int'(bus.VALID0 & bus.VALID1), 0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: VALID0=%0b VALID1=%0b at cycle %0d, expected no pulse",
                             bus.VALID0, bus.VALID1, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("grant_port", bus.VALID1 ? 1 : 0, e.port);
                    chk("rdata", bus.VALID1 ? int'(bus.RDATA1) : int'(bus.RDATA0), int'(e.data));
                    chk("latency_cycle", cyc, e.due);
                    if (e.port == 0) begin
                        chk("rdata1_hold", int'(bus.RDATA1), int'(exp_rd1));
                        exp_rd0 = e.data;
                    end else begin
                        chk("rdata0_hold", int'(bus.RDATA0), int'(exp_rd0));
                        exp_rd1 = e.data;
                    end
                end
            end
        end
    end

    // Requester: holds REQ/ADDR until n VALID pulses on its port, then drops REQ
    task automatic do_req(input int p, input logic [7:0] a, input int n);
        int got;
        int waited;
        got = 0;
        waited = 0;
        if (p == 0) begin
            bus.REQ0  = 1'b1;
            bus.ADDR0 = a;
        end else begin
            bus.REQ1  = 1'b1;
            bus.ADDR1 = a;
        end
        while (got < n && waited < 40 * n) begin
            @(negedge CLK);
            waited++;
            if ((p == 0 && bus.VALID0) || (p == 1 && bus.VALID1)) got++;
        end
        chk(p == 0 ? "req0_done" : "req1_done", got, n);
        if (p == 0) bus.REQ0 = 1'b0;
        else        bus.REQ1 = 1'b0;
    endtask

    task automatic apply_reset();
        RESET_N  = 1'b0;
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        repeat (2) @(negedge CLK);
        exp_rd0 = '0;
        exp_rd1 = '0;
        RESET_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int t;
        RESET_N   = 1'b0;
        bus.REQ0  = 1'b0;
        bus.REQ1  = 1'b0;
        bus.ADDR0 = '0;
        bus.ADDR1 = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_valid0",   int'(bus.VALID0),   0);
        chk("rst_valid1",   int'(bus.VALID1),   0);
        chk("rst_rdata0",   int'(bus.RDATA0),   0);
        chk("rst_rdata1",   int'(bus.RDATA1),   0);
        chk("rst_rom_addr", int'(bus.ROM_ADDR), 0);
        chk("rst_busy",     int'(bus.BUSY),     0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Single read of 0x10, 3-edge latency, BUSY for 2 cycles
        t = cyc;
        push(0, 8'hA5, t + 3);
        fork
            do_req(0, 8'h10, 1);
            begin
                @(negedge CLK);
                chk("t1_rom_addr", int'(bus.ROM_ADDR), 8'h10);
                chk("t1_busy_issue", int'(bus.BUSY), 1);
                @(negedge CLK);
                chk("t1_busy_read", int'(bus.BUSY), 1);
                @(negedge CLK);
                chk("t1_busy_valid", int'(bus.BUSY), 0);
            end
        join

        // Tie after reset goes to port 0, then port 1
        apply_reset();
        t = cyc;
        push(0, 8'hB4, t + 3);
        push(1, 8'hB7, t + 6);
        fork
            do_req(0, 8'h01, 1);
            do_req(1, 8'h02, 1);
        join

        // Port 0 served last, so the next tie goes to port 1
        t = cyc;
        push(0, 8'hF5, t + 3);
        do_req(0, 8'h40, 1);
        t = cyc;
        push(1, 8'hF7, t + 3);
        push(0, 8'hF4, t + 6);
        fork
            do_req(0, 8'h41, 1);
            do_req(1, 8'h42, 1);
        join

        // Both held continuously: grants 0,1,0,1
        apply_reset();
        t = cyc;
        push(0, 8'h86, t + 3);
        push(1, 8'h4A, t + 6);
        push(0, 8'h86, t + 9);
        push(1, 8'h4A, t + 12);
        fork
            do_req(0, 8'h33, 2);
            do_req(1, 8'hFF, 2);
        join

        // Reset during READ: request lost, outputs zero
        t = cyc;
        bus.REQ0  = 1'b1;
        bus.ADDR0 = 8'h10;
        repeat (2) @(negedge CLK);
        chk("t4_busy_before_rst", int'(bus.BUSY), 1);
        RESET_N  = 1'b0;
        bus.REQ0 = 1'b0;
        #1;
        chk("t4_valid0",   int'(bus.VALID0),   0);
        chk("t4_valid1",   int'(bus.VALID1),   0);
        chk("t4_rdata0",   int'(bus.RDATA0),   0);
        chk("t4_rdata1",   int'(bus.RDATA1),   0);
        chk("t4_rom_addr", int'(bus.ROM_ADDR), 0);
        chk("t4_busy",     int'(bus.BUSY),     0);
        repeat (2) begin
            @(negedge CLK);
            chk("t4_valid0_in_rst", int'(bus.VALID0), 0);
        end
        exp_rd0 = '0;
        exp_rd1 = '0;
        RESET_N = 1'b1;
        @(negedge CLK);
        t = cyc;
        push(0, 8'h94, t + 3);
        do_req(0, 8'h21, 1);

        // Hit buffer: re-read of the last address
        t = cyc;
        push(0, 8'h95, t + 3);
        do_req(0, 8'h20, 1);
        t = cyc;
`ifdef ROM_ARB_LASTHIT_EN
        push(0, 8'h95, t + 1);
`else
        push(0, 8'h95, t + 3);
`endif
        fork
            do_req(0, 8'h20, 1);
            begin
                @(negedge CLK);
                chk("t5_rom_addr", int'(bus.ROM_ADDR), 8'h20);
`ifdef ROM_ARB_LASTHIT_EN
                chk("t5_busy_hit", int'(bus.BUSY), 0);
`else
                chk("t5_busy_miss", int'(bus.BUSY), 1);
`endif
            end
        join
        t = cyc;
        push(0, 8'h94, t + 3);
        do_req(0, 8'h21, 1);

        // Port 1 sweeps the full address space and wraps to 0x00
        for (int i = 0; i <= 256; i++) begin
            logic [7:0] a;
            a = i[7:0];
            t = cyc;
            push(1, a ^ 8'hB5, t + 3);
            do_req(1, a, 1);
        end

        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
